// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

  // One granted transfer as seen at the grant edge
  typedef struct packed {
    owner_t             owner;
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
  } xfer_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester ports, shared-memory port and stall for the memory port arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              mem_cs;
  logic              mem_oe;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic              stall;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output mem_cs, mem_oe, mem_we, mem_addr, mem_din, stall
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  mem_cs, mem_oe, mem_we, mem_addr, mem_din, stall
  );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Access-cycle down-counter: load, decrement, zero flag.
module wait_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory between instruction fetch and data load/store.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  mem_port_arbiter_if.slave  bus
);

  state_t state, state_nxt;
  owner_t own;
  logic   own_we;
  logic   grant;
  xfer_t  gnt_xfer;
  logic   cnt_zero_c;
  logic   cnt_dec;

  wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (grant),
    .load_val (CNT_W'(WAIT_CYCLES - 1)),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero_c)
  );

  assign cnt_dec = (state == ACC) && !cnt_zero_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and grant selection; data wins in IDLE, RESP only hands over
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gnt_xfer  = '0;
    case (state)
      IDLE: begin
        if (en && bus.dm_req) begin
          grant    = 1'b1;
          gnt_xfer = '{owner: DATA, we: bus.dm_we, addr: bus.dm_addr, wdata: bus.dm_wdata};
        end else if (en && bus.if_req) begin
          grant    = 1'b1;
          gnt_xfer = '{owner: FETCH, we: 1'b0, addr: bus.if_addr, wdata: '0};
        end
      end
      ACC: begin
        if (cnt_zero_c) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
        if ((own == DATA) && en && bus.if_req) begin
          grant    = 1'b1;
          gnt_xfer = '{owner: FETCH, we: 1'b0, addr: bus.if_addr, wdata: '0};
        end else if ((own == FETCH) && en && bus.dm_req) begin
          grant    = 1'b1;
          gnt_xfer = '{owner: DATA, we: bus.dm_we, addr: bus.dm_addr, wdata: bus.dm_wdata};
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant) state_nxt = ACC;
  end

  // Owner latch, read-data capture, acks and registered memory strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own          <= FETCH;
      own_we       <= 1'b0;
      bus.if_rdata <= '0;
      bus.dm_rdata <= '0;
      bus.if_ack   <= 1'b0;
      bus.dm_ack   <= 1'b0;
      bus.mem_cs   <= 1'b1;
      bus.mem_oe   <= 1'b1;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
    end else begin
      if (grant) begin
        own    <= gnt_xfer.owner;
        own_we <= gnt_xfer.we;
      end

      if ((state == ACC) && cnt_zero_c && !own_we) begin
        if (own == DATA) bus.dm_rdata <= bus.mem_dout;
        else             bus.if_rdata <= bus.mem_dout;
      end

      bus.if_ack <= (state_nxt == RESP) && (own == FETCH);
      bus.dm_ack <= (state_nxt == RESP) && (own == DATA);

      if (grant) begin
        bus.mem_cs   <= 1'b0;
        bus.mem_oe   <= gnt_xfer.we;
        bus.mem_we   <= gnt_xfer.we;
        bus.mem_addr <= gnt_xfer.addr;
        if (gnt_xfer.we) bus.mem_din <= gnt_xfer.wdata;
      end else if (state_nxt != ACC) begin
        bus.mem_cs <= 1'b1;
        bus.mem_oe <= 1'b1;
        bus.mem_we <= 1'b0;
      end
    end
  end

  // PC hold while any request is still outstanding
  assign bus.stall = (bus.if_req & ~bus.if_ack) | (bus.dm_req & ~bus.dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with ack-driven scoreboards (W=1 and W=3).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam logic [31:0] MEM_KEY = 32'h2002_0045;

  typedef struct {
    logic        data;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst1_n, rst3_n, en1, en3;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb1[$];
  exp_t sb3[$];
  exp_t e1, e3;

  mem_port_arbiter_if b1();
  mem_port_arbiter_if b3();

  mem_port_arbiter #(.WAIT_CYCLES(1)) u1 (.clk(clk), .reset(rst1_n), .en(en1), .bus(b1.slave));
  mem_port_arbiter #(.WAIT_CYCLES(3)) u3 (.clk(clk), .reset(rst3_n), .en(en3), .bus(b3.slave));

  // Memory model: read data is a fixed function of the address
  assign b1.mem_dout = b1.mem_addr ^ MEM_KEY;
  assign b3.mem_dout = b3.mem_addr ^ MEM_KEY;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the W=1 instance
  always @(negedge clk) begin
    if (rst1_n && (b1.if_ack || b1.dm_ack)) begin
      check("u1_ack_excl", 32'(b1.if_ack & b1.dm_ack), 32'd0);
      check("u1_sb_pending", 32'(sb1.size() != 0), 32'd1);
      if (sb1.size() != 0) begin
        e1 = sb1.pop_front();
        check("u1_ack_owner", 32'(b1.dm_ack), 32'(e1.data));
        check("u1_rdata", e1.data ? b1.dm_rdata : b1.if_rdata, e1.rdata);
      end
    end
  end

  // Scoreboard for the W=3 instance
  always @(negedge clk) begin
    if (rst3_n && (b3.if_ack || b3.dm_ack)) begin
      check("u3_ack_excl", 32'(b3.if_ack & b3.dm_ack), 32'd0);
      check("u3_sb_pending", 32'(sb3.size() != 0), 32'd1);
      if (sb3.size() != 0) begin
        e3 = sb3.pop_front();
        check("u3_ack_owner", 32'(b3.dm_ack), 32'(e3.data));
        check("u3_rdata", e3.data ? b3.dm_rdata : b3.if_rdata, e3.rdata);
      end
    end
  end

  // Follow one W=3 transfer from the grant edge to its ack, tallying strobes
  task automatic run3(input int drop_at, output int lat, output int cs_n,
                      output int we_n, output logic [31:0] din);
    bit got;
    got = 1'b0; lat = 0; cs_n = 0; we_n = 0; din = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b3.mem_cs == 1'b0) cs_n++;
      if (b3.mem_we) begin we_n++; din = b3.mem_din; end
      if (i == drop_at) b3.dm_req = 1'b0;
      if (b3.dm_ack || b3.if_ack) begin lat = i; got = 1'b1; break; end
    end
    check("u3_ack_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cs_n, we_n;
    logic [31:0] din;

    rst1_n = 1'b0; rst3_n = 1'b0; en1 = 1'b1; en3 = 1'b1;
    b1.if_req = 0; b1.if_addr = '0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = '0; b1.dm_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_addr = '0; b3.dm_wdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cs",    32'(b1.mem_cs), 32'd1);
    check("rst_oe",    32'(b1.mem_oe), 32'd1);
    check("rst_we",    32'(b1.mem_we), 32'd0);
    check("rst_addr",  b1.mem_addr, 32'd0);
    check("rst_acks",  32'({b1.if_ack, b1.dm_ack}), 32'd0);
    check("rst_rdata", b1.dm_rdata | b1.if_rdata, 32'd0);
    check("rst3_cs",   32'(b3.mem_cs), 32'd1);
    rst1_n = 1'b1; rst3_n = 1'b1;

    // Single fetch, W=1
    @(posedge clk); #1;
    b1.if_addr = 32'h0000_0040; b1.if_req = 1'b1;
    sb1.push_back('{1'b0, 32'h2002_0005});
    @(negedge clk);
    check("A_stall_idle", 32'(b1.stall), 32'd1);
    check("A_cs_pre",     32'(b1.mem_cs), 32'd1);
    @(negedge clk);
    check("A_cs_acc",   32'(b1.mem_cs), 32'd0);
    check("A_addr",     b1.mem_addr, 32'h0000_0040);
    check("A_oe",       32'(b1.mem_oe), 32'd0);
    check("A_we",       32'(b1.mem_we), 32'd0);
    check("A_ack_early",32'(b1.if_ack), 32'd0);
    @(negedge clk);
    check("A_ack",       32'(b1.if_ack), 32'd1);
    check("A_cs_resp",   32'(b1.mem_cs), 32'd1);
    check("A_stall_ack", 32'(b1.stall), 32'd0);
    b1.if_req = 1'b0;
    @(negedge clk);
    check("A_ack_once",  32'(b1.if_ack), 32'd0);
    check("A_rdata_hold",b1.if_rdata, 32'h2002_0005);

    // Simultaneous requests: data first, fetch granted from data RESP
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 32'h0000_0100;
    b1.if_req = 1'b1; b1.if_addr = 32'h0000_0044;
    sb1.push_back('{1'b1, 32'h2002_0145});
    sb1.push_back('{1'b0, 32'h2002_0001});
    @(negedge clk);
    check("B_data_first", b1.mem_addr, 32'h0000_0100);
    check("B_cs0",        32'(b1.mem_cs), 32'd0);
    @(negedge clk);
    check("B_dm_ack",  32'(b1.dm_ack), 32'd1);
    check("B_cs_resp", 32'(b1.mem_cs), 32'd1);
    b1.dm_req = 1'b0;
    @(negedge clk);
    check("B_fetch_addr", b1.mem_addr, 32'h0000_0044);
    check("B_no_idle",    32'(u1.state), 32'(ACC));
    @(negedge clk);
    check("B_if_ack", 32'(b1.if_ack), 32'd1);
    b1.if_req = 1'b0;
    @(negedge clk);
    check("B_idle_cs", 32'(b1.mem_cs), 32'd1);

    // en low blocks grants; raising it grants on the next edge
    en1 = 1'b0; b1.if_req = 1'b1; b1.if_addr = 32'h0000_0048;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("C_no_grant", 32'(b1.mem_cs), 32'd1);
      check("C_stall",    32'(b1.stall), 32'd1);
    end
    en1 = 1'b1;
    sb1.push_back('{1'b0, 32'h2002_000D});
    @(negedge clk);
    check("C_grant", 32'(b1.mem_cs), 32'd0);
    check("C_addr",  b1.mem_addr, 32'h0000_0048);
    @(negedge clk);
    check("C_ack", 32'(b1.if_ack), 32'd1);
    b1.if_req = 1'b0;

    // W=3 read with dm_req dropped in the second ACC cycle
    @(negedge clk);
    b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 32'h0000_0100;
    sb3.push_back('{1'b1, 32'h2002_0145});
    run3(1, lat, cs_n, we_n, din);
    check("D_lat",  32'(lat), 32'd3);
    check("D_cs_n", 32'(cs_n), 32'd3);
    check("D_we_n", 32'(we_n), 32'd0);

    // W=3 write: three write cycles, dm_rdata untouched
    @(negedge clk);
    b3.dm_req = 1'b1; b3.dm_we = 1'b1; b3.dm_addr = 32'h0000_0008; b3.dm_wdata = 32'hDEAD_BEEF;
    sb3.push_back('{1'b1, 32'h2002_0145});
    run3(-1, lat, cs_n, we_n, din);
    b3.dm_req = 1'b0;
    check("E_lat",  32'(lat), 32'd3);
    check("E_cs_n", 32'(cs_n), 32'd3);
    check("E_we_n", 32'(we_n), 32'd3);
    check("E_din",  din, 32'hDEAD_BEEF);
    @(negedge clk);
    check("E_we_off",   32'(b3.mem_we), 32'd0);
    check("E_ack_once", 32'(b3.dm_ack), 32'd0);
    check("E_addr_hold",b3.mem_addr, 32'h0000_0008);
    check("E_din_hold", b3.mem_din, 32'hDEAD_BEEF);
    check("E_rdata",    b3.dm_rdata, 32'h2002_0145);

    // Reset in the second ACC cycle of a write aborts it
    b3.dm_req = 1'b1; b3.dm_we = 1'b1; b3.dm_addr = 32'h0000_000C; b3.dm_wdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    check("F_we_acc2", 32'(b3.mem_we), 32'd1);
    #2 rst3_n = 1'b0;
    #1;
    check("F_we_rst",    32'(b3.mem_we), 32'd0);
    check("F_cs_rst",    32'(b3.mem_cs), 32'd1);
    check("F_oe_rst",    32'(b3.mem_oe), 32'd1);
    check("F_addr_rst",  b3.mem_addr, 32'd0);
    check("F_din_rst",   b3.mem_din, 32'd0);
    check("F_rdata_rst", b3.dm_rdata, 32'd0);
    b3.dm_req = 1'b0; b3.dm_we = 1'b0;
    @(negedge clk);
    rst3_n = 1'b1;
    repeat (2) @(negedge clk);
    check("F_idle",   32'(u3.state), 32'(IDLE));
    check("F_no_ack", 32'(b3.dm_ack), 32'd0);
    check("F_cs_idle",32'(b3.mem_cs), 32'd1);

    // Every expected transfer must have completed
    repeat (2) @(negedge clk);
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    check("sb3_drained", 32'(sb3.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, SHALL set memory access cycles per transfer; legal 1..7.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port en  input  1  SHALL, when high, permit new grants.
REQ-005 Ports if_req (in 1), if_addr (in 32), if_rdata (out 32), if_ack (out 1) SHALL form the instruction-fetch requester port.
REQ-006 Ports dm_req (in 1), dm_we (in 1), dm_addr (in 32), dm_wdata (in 32), dm_rdata (out 32), dm_ack (out 1) SHALL form the data load/store requester port.
REQ-007 Ports mem_cs (out 1, low = selected), mem_oe (out 1, low = drive read data), mem_we (out 1, high = write), mem_addr (out 32), mem_din (out 32), mem_dout (in 32) SHALL drive the single shared memory.
REQ-008 Port stall  output  1  SHALL indicate the PC must hold.

Function
REQ-009 FSM states SHALL be IDLE, ACC, RESP.
REQ-010 IDLE: if en and dm_req, grant data; else if en and if_req, grant fetch; else stay IDLE.
REQ-011 Simultaneous dm_req and if_req in IDLE SHALL grant data first.
REQ-012 On grant, next state SHALL be ACC; owner, address, write flag and write data SHALL be latched at the grant edge.
REQ-013 ACC SHALL last exactly WAIT_CYCLES cycles, counted by a 3-bit down-counter loaded with WAIT_CYCLES-1.
REQ-014 During ACC: mem_cs=0, mem_addr=latched address; read: mem_oe=0, mem_we=0; write: mem_oe=1, mem_we=1, mem_din=latched wdata.
REQ-015 Outside ACC: mem_cs=1, mem_oe=1, mem_we=0, mem_addr and mem_din hold last value.
REQ-016 Last ACC cycle edge SHALL capture mem_dout into owner's rdata register (reads only) and enter RESP.
REQ-017 RESP SHALL assert owner's ack for exactly one cycle; the other ack stays 0.
REQ-018 RESP SHALL grant only the non-owner requester (if en and its req high, go directly to ACC); otherwise return to IDLE.
REQ-019 Request-to-ack latency SHALL be WAIT_CYCLES+1 cycles from the grant edge; no-bubble alternation throughput one transfer per WAIT_CYCLES+1 cycles.
REQ-020 if_rdata/dm_rdata SHALL hold value until the next read for that port; writes leave dm_rdata unchanged.
REQ-021 Requesters hold req and payload until ack; a req dropped mid-ACC SHALL not abort the transfer and ack still pulses.
REQ-022 en low SHALL block new grants only; an in-flight ACC/RESP completes.
REQ-023 stall SHALL equal combinational (if_req & ~if_ack) | (dm_req & ~dm_ack).

Reset
REQ-024 reset low SHALL asynchronously force IDLE, counter 0, if_ack=dm_ack=0, if_rdata=dm_rdata=0, mem_cs=1, mem_oe=1, mem_we=0, mem_addr=mem_din=0.
REQ-025 reset asserted mid-ACC SHALL abort the transfer with no ack; mem_we deasserts immediately.
REQ-026 First grant SHALL occur no earlier than the first rising edge after reset deasserts.

Structure
REQ-027 State encoding (IDLE, ACC, RESP) and owner encoding (FETCH, DATA) SHALL live in the shared CPU package.
REQ-028 Wait counter SHALL be a sub-module wait_counter (load, decrement, zero flag); remaining logic flat.

Verification
REQ-029 WAIT_CYCLES=1, if_req only, if_addr=0x0000_0040, mem_dout=0x2002_0005 -> mem_cs low 1 cycle, if_ack 2 cycles after grant, if_rdata=0x2002_0005.
REQ-030 if_req and dm_req (read 0x100) together -> data ACC first, fetch ACC begins in data RESP cycle, no IDLE between.
REQ-031 WAIT_CYCLES=3, dm write addr 0x8, wdata 0xDEAD_BEEF -> mem_we high exactly 3 cycles, dm_ack one cycle, dm_rdata unchanged.
REQ-032 en low while if_req high -> no grant, stall=1; en raised -> grant next edge.
REQ-033 reset pulsed low in 2nd of 3 ACC cycles -> outputs at reset values immediately, no ack, IDLE after release.
REQ-034 dm_req dropped mid-ACC -> transfer completes, dm_ack pulses once.
